// File: rtl/pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pci_bus_arbiter
//  Purpose  : Central round-robin arbiter for a shared PCI-style bus.
//             Samples the active-low per-device requests, hands out a single
//             active-low grant, watches iframe/iready to know when the
//             current transaction has ended, and revokes grants from masters
//             that never start a transaction within GNT_TIMEOUT cycles.
//
//  Ports    : clk          bus clock, all logic on the rising edge
//             reset        synchronous, active-high reset
//             request      active-low request, bit i from device i
//             iframe       bus iframe (active-low), monitored only
//             iready       bus iready (active-low), monitored only
//             grant        active-low grant, bit i to device i (registered)
//             owner        index of the granted/owning master (registered)
//             bus_busy     registered "iframe low or iready low"
//             timeout_evt  one-cycle pulse when a grant is revoked by timeout
//
//  Option   : ARB_BUS_PARK_EN - when defined, an idle bus with no pending
//             request parks the grant on master 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module pci_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] request,
    input  logic                   iframe,
    input  logic                   iready,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       owner,
    output logic                   bus_busy,
    output logic                   timeout_evt
);

    localparam int              c_CNT_W    = $clog2(GNT_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(GNT_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;  // no owner, grant all ones
    localparam logic [1:0] c_ST_GNT  = 2'd1;  // granted, waiting for iframe
    localparam logic [1:0] c_ST_BUSY = 2'd2;  // owner's transaction running
`ifdef ARB_BUS_PARK_EN
    localparam logic [1:0] c_ST_PARK = 2'd3;  // grant parked on master 0
`endif

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       w_ptr_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [NUM_MASTERS-1:0] r_req;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IDX_W-1:0]       w_owner_nxt;
    logic                   w_timeout_nxt;
    logic                   w_bus_idle;
    logic                   w_any_req;
    logic [IDX_W-1:0]       w_winner;

    // (base + offs) mod NUM_MASTERS, offs < NUM_MASTERS
    function automatic logic [IDX_W-1:0] f_rr_idx(input logic [IDX_W-1:0] base,
                                                  input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
        end
        return IDX_W'(sum);
    endfunction

    assign w_bus_idle = iframe & iready;
    assign w_any_req  = ~(&r_req);

    // Round-robin search from r_ptr. Scanning from the far end down lets the
    // closest requester to the pointer overwrite any farther one.
    always_comb begin
        w_winner = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (!r_req[f_rr_idx(r_ptr, k)]) begin
                w_winner = f_rr_idx(r_ptr, k);
            end
        end
    end

    // Next-state / next-output logic. Releasing ownership always returns to
    // IDLE with grant all ones, which guarantees the turnaround cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = grant;
        w_owner_nxt   = owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_grant_nxt = '1;
                if (w_bus_idle && w_any_req) begin
                    w_grant_nxt = ~(NUM_MASTERS'(1) << w_winner);
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_GNT;
                end
`ifdef ARB_BUS_PARK_EN
                else if (w_bus_idle) begin
                    w_grant_nxt = ~NUM_MASTERS'(1);
                    w_owner_nxt = '0;
                    w_state_nxt = c_ST_PARK;
                end
`endif
            end

            c_ST_GNT: begin
                // iframe has priority over both withdrawal and timeout
                if (!iframe) begin
                    w_state_nxt = c_ST_BUSY;
                end else if (r_req[owner]) begin
                    w_grant_nxt = '1;
                    w_ptr_nxt   = f_rr_idx(owner, 1);
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_grant_nxt   = '1;
                    w_ptr_nxt     = f_rr_idx(owner, 1);
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            c_ST_BUSY: begin
                if (w_bus_idle) begin
                    w_grant_nxt = '1;
                    w_ptr_nxt   = f_rr_idx(owner, 1);
                    w_state_nxt = c_ST_IDLE;
                end
            end

`ifdef ARB_BUS_PARK_EN
            c_ST_PARK: begin
                // Parking is not ownership: the pointer only moves once
                // master 0 actually runs a transaction.
                if (!iframe) begin
                    w_state_nxt = c_ST_BUSY;
                end else if (|(~r_req[NUM_MASTERS-1:1])) begin
                    w_grant_nxt = '1;
                    w_state_nxt = c_ST_IDLE;
                end else if (!r_req[0]) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_GNT;
                end
            end
`endif

            default: begin
                w_grant_nxt = '1;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_req       <= '1;
            grant       <= '1;
            owner       <= '0;
            bus_busy    <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req       <= request;
            grant       <= w_grant_nxt;
            owner       <= w_owner_nxt;
            bus_busy    <= ~w_bus_idle;
            timeout_evt <= w_timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pci_bus_arbiter
//  Purpose  : Self-checking bench for pci_bus_arbiter: directed scenarios with
//             literal expectations followed by randomized requests and bus
//             traffic compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pci_bus_arbiter;

    localparam int NUM_M  = 4;
    localparam int IDX_W  = 2;
    localparam int GNT_TO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NUM_M-1:0] request;
    logic             iframe;
    logic             iready;
    logic [NUM_M-1:0] grant;
    logic [IDX_W-1:0] owner;
    logic             bus_busy;
    logic             timeout_evt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    pci_bus_arbiter #(
        .NUM_MASTERS (NUM_M),
        .IDX_W       (IDX_W),
        .GNT_TIMEOUT (GNT_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .iframe      (iframe),
        .iready      (iready),
        .grant       (grant),
        .owner       (owner),
        .bus_busy    (bus_busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who holds the bus (-1 = nobody), whether their
    // transaction has started, how long they have held an unused grant.
    // Arbitration decisions use the request vector seen on the previous edge.
    // ------------------------------------------------------------------
    int             m_holder;
    bit             m_started;
    int             m_age;
    int             m_ptr;
    logic [NUM_M-1:0] m_req_d;
    int             m_owner;
    bit             m_busy;
    bit             m_to;
    bit             m_idle;
    int             m_pick;

    always @(posedge clk) begin
        if (reset) begin
            m_holder = -1; m_started = 0; m_age = 0; m_ptr = 0;
            m_req_d = '1; m_owner = 0; m_busy = 0; m_to = 0;
        end else begin
            m_idle = iframe && iready;
            m_to = 0;
            if (m_holder < 0) begin
                if (m_idle && m_req_d != '1) begin
                    m_pick = -1;
                    for (int k = 0; k < NUM_M; k++) begin
                        if (m_pick < 0 && !m_req_d[(m_ptr + k) % NUM_M])
                            m_pick = (m_ptr + k) % NUM_M;
                    end
                    m_holder = m_pick; m_owner = m_pick;
                    m_started = 0; m_age = 0;
                end
            end else if (!m_started) begin
                if (!iframe) begin
                    m_started = 1;
                end else if (m_req_d[m_holder]) begin
                    m_ptr = (m_holder + 1) % NUM_M; m_holder = -1;
                end else begin
                    m_age++;
                    if (m_age == GNT_TO) begin
                        m_to = 1; m_ptr = (m_holder + 1) % NUM_M; m_holder = -1;
                    end
                end
            end else if (m_idle) begin
                m_ptr = (m_holder + 1) % NUM_M; m_holder = -1;
            end
            m_req_d = request;
            m_busy  = !m_idle;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison on the falling edge, plus grant properties.
    // ------------------------------------------------------------------
    logic [NUM_M-1:0] prev_grant = '1;
    logic [NUM_M-1:0] exp_grant;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_grant = (m_holder < 0) ? '1 : ~(NUM_M'(1) << m_holder);
            chk("grant",       32'(grant),       32'(exp_grant));
            chk("owner",       32'(owner),       32'(m_owner));
            chk("bus_busy",    32'(bus_busy),    32'(m_busy));
            chk("timeout_evt", 32'(timeout_evt), 32'(m_to));
            chk("grant_onehot", 32'($countones(~grant) <= 1), 32'(1));
            chk("owner_range",  32'(int'(owner) < NUM_M), 32'(1));
            if (prev_grant != '1 && grant != '1)
                chk("turnaround", 32'(grant), 32'(prev_grant));
            prev_grant = grant;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int txn_left;

    initial begin
        reset = 1'b1; request = '1; iframe = 1'b1; iready = 1'b1;
        @(posedge clk); #1; chk_en = 1'b1;
        step(1);
        // reset state
        chk("rst_grant", 32'(grant), 32'hF);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy",  32'(bus_busy), 32'h0);
        reset = 1'b0;

        // single request from master 0: grant two edges later
        request = 4'b1110;
        step(1); chk("lat_grant_e1", 32'(grant), 32'hF);
        step(1); chk("lat_grant_e2", 32'(grant), 32'hE);
        chk("lat_owner", 32'(owner), 32'h0);
        iframe = 1'b0;
        step(1); chk("busy_flag", 32'(bus_busy), 32'h1);
        step(2);
        iframe = 1'b1; request = 4'b1111;
        step(1); chk("release_grant", 32'(grant), 32'hF);
        step(1);

        // master 1 never starts: timeout after GNT_TO cycles
        request = 4'b1101;
        step(2); chk("to_grant", 32'(grant), 32'hD);
        request = 4'b1001;
        step(GNT_TO - 1);
        chk("to_not_yet", 32'(timeout_evt), 32'h0);
        step(1);
        chk("to_pulse", 32'(timeout_evt), 32'h1);
        chk("to_release", 32'(grant), 32'hF);
        step(1);
        chk("to_ptr_next", 32'(grant), 32'hB);
        chk("to_pulse_end", 32'(timeout_evt), 32'h0);

        // master 2 withdraws before iframe
        request = 4'b1101;
        step(2);
        chk("wd_release", 32'(grant), 32'hF);
        chk("wd_no_to", 32'(timeout_evt), 32'h0);
        step(1);
        chk("wd_next", 32'(grant), 32'hD);

        // reset in the middle of a transaction
        iframe = 1'b0;
        step(2);
        reset = 1'b1; request = 4'b0101;
        step(1);
        chk("mid_rst_grant", 32'(grant), 32'hF);
        chk("mid_rst_owner", 32'(owner), 32'h0);
        chk("mid_rst_busy",  32'(bus_busy), 32'h0);
        reset = 1'b0; iframe = 1'b1;
        step(2);
        chk("post_rst_lowest", 32'(grant), 32'hD);
        request = '1;
        step(3);

        // randomized phase
        txn_left = 0;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) request = NUM_M'($urandom_range(0, 15));
            if (txn_left > 0) begin
                iframe = (txn_left > 1) ? 1'b0 : 1'b1;
                iready = ($urandom_range(0, 1) == 0) ? 1'b0 : (txn_left > 1 ? 1'b1 : 1'b0);
                txn_left--;
            end else begin
                iframe = 1'b1; iready = 1'b1;
                if ((grant != '1 && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0)
                    txn_left = $urandom_range(2, 5);
            end
            step(1);
        end

        reset = 1'b0; request = '1; iframe = 1'b1; iready = 1'b1;
        step(4);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
